// File: rtl/round_key_sched.sv
// -----------------------------------------------------------------------------
// round_key_sched
//   Subkey generator for the 8-bit Feistel round stage. A 12-bit master key is
//   split into two 6-bit halves C/D that are rotated left once per round
//   (1,1,2,2,... bits, cumulative); each round selects six bits into a subkey.
//   All NROUNDS subkeys are generated into a buffer first, then streamed out
//   over valid/ready in forward order (encrypt) or reverse order (decrypt).
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   job request, sampled only in IDLE
//   mkey       in   [11:0] master key, captured on accepted start
//   decrypt    in   0 = forward subkey order, 1 = reverse
//   busy       out  high while generating or emitting
//   key_valid  out  subkey/round_idx/last are valid
//   key_ready  in   round stage accepts the current subkey
//   subkey     out  [5:0] current round key
//   round_idx  out  [2:0] emission count of the current subkey
//   last       out  final subkey of the job
//   done       out  one-cycle pulse after the final handshake
// -----------------------------------------------------------------------------
module round_key_sched #(
    parameter int NROUNDS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [11:0] mkey,
    input  logic       decrypt,
    output logic       busy,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [5:0] subkey,
    output logic [2:0] round_idx,
    output logic       last,
    output logic       done
);

    localparam logic [2:0] LAST_IDX = 3'(NROUNDS - 1);

    typedef enum logic [1:0] {IDLE, GEN, EMIT} state_t;

    state_t      state, state_n;
    logic [5:0]  c_reg, d_reg;
    logic        dec_reg;
    logic [2:0]  gen_cnt;
    // Sized for the largest legal NROUNDS so any 3-bit index is in range.
    logic [5:0]  key_buf [8];

    logic [5:0]  c_rot, d_rot, gen_key;
    logic [2:0]  idx_inc;
    logic        xfer;

    logic        busy_n, key_valid_n, last_n, done_n;
    logic [5:0]  subkey_n;
    logic [2:0]  round_idx_n;

    assign xfer    = key_valid && key_ready;
    assign idx_inc = round_idx + 3'd1;

    // Buffer slot holding the subkey for a given emission count.
    function automatic logic [2:0] slot(input logic [2:0] idx, input logic dec);
        return dec ? (LAST_IDX - idx) : idx;
    endfunction

    // Rounds 1 and 2 rotate by one bit, all later rounds by two.
    always_comb begin
        if (gen_cnt < 3'd2) begin
            c_rot = {c_reg[4:0], c_reg[5]};
            d_rot = {d_reg[4:0], d_reg[5]};
        end else begin
            c_rot = {c_reg[3:0], c_reg[5:4]};
            d_rot = {d_reg[3:0], d_reg[5:4]};
        end
        gen_key = {c_rot[4], c_rot[1], c_rot[0], d_rot[5], d_rot[3], d_rot[2]};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so every path drives state_n; no latch.
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = GEN;
            GEN:     if (gen_cnt == LAST_IDX) state_n = EMIT;
            EMIT:    if (xfer && last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs. The first EMIT
    // cycle loads the first subkey; each handshake then loads the next one,
    // so outputs hold unchanged while key_ready is low.
    always_comb begin
        key_valid_n = key_valid;
        subkey_n    = subkey;
        round_idx_n = round_idx;
        last_n      = last;
        done_n      = 1'b0;
        busy_n      = (state_n != IDLE);
        if (state == EMIT) begin
            if (!key_valid) begin
                key_valid_n = 1'b1;
                round_idx_n = 3'd0;
                subkey_n    = key_buf[slot(3'd0, dec_reg)];
                last_n      = (LAST_IDX == 3'd0);
            end else if (xfer) begin
                if (last) begin
                    key_valid_n = 1'b0;
                    last_n      = 1'b0;
                    subkey_n    = '0;
                    round_idx_n = '0;
                    done_n      = 1'b1;
                end else begin
                    round_idx_n = idx_inc;
                    subkey_n    = key_buf[slot(idx_inc, dec_reg)];
                    last_n      = (idx_inc == LAST_IDX);
                end
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            key_valid <= 1'b0;
            subkey    <= '0;
            round_idx <= '0;
            last      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every flop
            // samples pre-edge values regardless of statement order.
            busy      <= busy_n;
            key_valid <= key_valid_n;
            subkey    <= subkey_n;
            round_idx <= round_idx_n;
            last      <= last_n;
            done      <= done_n;
        end
    end

    // Key halves, order flag and generation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_reg   <= '0;
            d_reg   <= '0;
            dec_reg <= 1'b0;
            gen_cnt <= '0;
        end else if (state == IDLE && start) begin
            c_reg   <= mkey[11:6];
            d_reg   <= mkey[5:0];
            dec_reg <= decrypt;
            gen_cnt <= '0;
        end else if (state == GEN) begin
            c_reg   <= c_rot;
            d_reg   <= d_rot;
            gen_cnt <= gen_cnt + 3'd1;
        end
    end

    // NOTE: the subkey buffer has no reset; every slot read in EMIT is
    // written during GEN of the same job, so a reset would only cost area.
    always_ff @(posedge clk) begin
        if (state == GEN) key_buf[gen_cnt] <= gen_key;
    end

endmodule
